// File: rtl/aes_block_serializer_pkg.sv
// rtl/aes_block_serializer_pkg.sv - shared widths and control/flag types for the AES block serializer
package aes_block_serializer_pkg;

   localparam int unsigned AES_BLK_W   = 128;
   localparam int unsigned AES_WORD_W  = 32;
   localparam int unsigned SER_CNT_LEN = 16;

   typedef struct packed {
      logic                   clear;
      logic                   enable;
      logic [SER_CNT_LEN-1:0] len;
   } ctrl_serializer_t;

   typedef struct packed {
      logic [SER_CNT_LEN-1:0] cnt;
      logic                   busy;
      logic                   done;
   } flags_serializer_t;

endpackage

// File: rtl/aes_block_serializer_if.sv
// rtl/aes_block_serializer_if.sv - valid/ready stream bundle with data and byte strobes
interface aes_block_serializer_if
   import aes_block_serializer_pkg::*;
#(
   parameter int unsigned DW = AES_WORD_W
) ();

   logic [DW-1:0]   data;
   logic            valid;
   logic            ready;
   logic [DW/8-1:0] strb;

   modport master (output data, output valid, output strb, input ready);
   modport slave  (input data, input valid, input strb, output ready);

endinterface

// File: rtl/aes_block_serializer.sv
// rtl/aes_block_serializer.sv - splits 128-bit AES blocks into 32-bit words and counts finished blocks
module aes_block_serializer
   import aes_block_serializer_pkg::*;
#(
   parameter int unsigned BLK_W  = AES_BLK_W,
   parameter int unsigned WORD_W = AES_WORD_W,
   parameter int unsigned CNT_W  = SER_CNT_LEN
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   aes_block_serializer_if.slave         blk_i,
   aes_block_serializer_if.master        word_o,
   input  ctrl_serializer_t              ctrl_i,
   output flags_serializer_t             flags_o
);

   localparam int unsigned NWORDS = BLK_W / WORD_W;
   localparam int unsigned IDX_W  = $clog2(NWORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   logic [BLK_W-1:0]                   r_blk;
   logic                               r_full;
   logic [IDX_W-1:0]                   r_idx;
   logic [CNT_W-1:0]                   r_cnt;

   logic [NWORDS-1:0][WORD_W-1:0]      blk_words;
   logic                               en;
   logic                               lim;
   logic                               word_hs;
   logic                               last_hs;
   logic                               blk_hs;

   assign en        = ctrl_i.enable;
   assign lim       = (ctrl_i.len != '0) && (r_cnt == ctrl_i.len);
   assign blk_words = r_blk;

   assign word_o.valid = en & r_full;
   assign word_o.data  = blk_words[r_idx];
   assign word_o.strb  = '1;

   assign word_hs = word_o.valid & word_o.ready;
   assign last_hs = word_hs & (r_idx == LAST_IDX);

   // Reset gating keeps ready low while rst_ni is asserted even if enable is still high.
   assign blk_i.ready = rst_ni & en & ~lim & (~r_full | last_hs);
   assign blk_hs      = blk_i.valid & blk_i.ready;

   assign flags_o.cnt  = r_cnt;
   assign flags_o.busy = r_full;
   assign flags_o.done = lim & ~r_full;

   // Holding register, word index and block counter; clear beats enable, enable low freezes everything.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_blk  <= '0;
         r_full <= 1'b0;
         r_idx  <= '0;
         r_cnt  <= '0;
      end else if (ctrl_i.clear) begin
         r_full <= 1'b0;
         r_idx  <= '0;
         r_cnt  <= '0;
      end else if (en) begin
         if (blk_hs) begin
            r_blk  <= blk_i.data;
            r_full <= 1'b1;
            r_idx  <= '0;
         end else if (last_hs) begin
            r_full <= 1'b0;
            r_idx  <= '0;
         end else if (word_hs) begin
            r_idx  <= r_idx + 1'b1;
         end
         if (last_hs && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_aes_block_serializer.sv
// tb/tb_aes_block_serializer.sv - scoreboard bench for the AES block serializer
module tb_aes_block_serializer;
   import aes_block_serializer_pkg::*;

   logic clk_i;
   logic rst_ni;
   ctrl_serializer_t  ctrl;
   flags_serializer_t flags;

   aes_block_serializer_if #(.DW(128)) blk_if ();
   aes_block_serializer_if #(.DW(32))  word_if ();

   aes_block_serializer dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .blk_i   (blk_if),
      .word_o  (word_if),
      .ctrl_i  (ctrl),
      .flags_o (flags)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [15:0] m_cnt = '0;
   bit          prev_stall = 0;
   logic [31:0] prev_data = '0;

   int   rmode = 0;
   logic [3:0] pat = 4'b1001;
   int   pidx = 0;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Drives the word-side ready according to the current mode; mode 3 leaves it to the test.
   always @(posedge clk_i) begin
      #1;
      case (rmode)
         0: word_if.ready = 1'b1;
         1: begin word_if.ready = pat[3 - (pidx % 4)]; pidx++; end
         2: word_if.ready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   end

   // Reference model and scoreboard: a queue of words still owed, plus a saturating block count.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         exp_q.delete();
         m_cnt = '0;
         prev_stall = 0;
      end else begin
         automatic bit lim_m  = (ctrl.len != 0) && (m_cnt == ctrl.len);
         automatic bit last_m = ctrl.enable && word_if.ready && (exp_q.size() == 1);
         chk("word_valid", word_if.valid, ctrl.enable && (exp_q.size() != 0));
         chk("blk_ready", blk_if.ready, ctrl.enable && !lim_m && ((exp_q.size() == 0) || last_m));
         chk("flag_cnt", flags.cnt, m_cnt);
         chk("flag_busy", flags.busy, exp_q.size() != 0);
         chk("flag_done", flags.done, lim_m && (exp_q.size() == 0));
         if (prev_stall && ctrl.enable) begin
            chk("stall_valid", word_if.valid, 1'b1);
            chk("stall_data", word_if.data, prev_data);
         end
         if (word_if.valid && word_if.ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", word_if.data, 128'hx);
            end else begin
               chk("word_data", word_if.data, exp_q.pop_front());
               chk("word_strb", word_if.strb, 4'hf);
               if ((exp_q.size() == 0) && (m_cnt != 16'hffff)) m_cnt = m_cnt + 16'd1;
            end
         end
         if (blk_if.valid && blk_if.ready) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(blk_if.data[k*32 +: 32]);
         end
         if (ctrl.enable) begin
            prev_stall = word_if.valid && !word_if.ready && !ctrl.clear;
            prev_data  = word_if.data;
         end
         if (ctrl.clear) begin
            exp_q.delete();
            m_cnt = '0;
            prev_stall = 0;
         end
      end
   end

   task automatic try_block(input logic [127:0] d, input int bound, output bit got);
      got = 0;
      blk_if.data  = d;
      blk_if.strb  = 16'($urandom);
      blk_if.valid = 1'b1;
      for (int i = 0; i < bound && !got; i++) begin
         @(negedge clk_i);
         if (blk_if.ready) got = 1;
      end
      @(posedge clk_i); #1;
      blk_if.valid = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] d);
      bit got;
      try_block(d, 300, got);
      chk("blk_accept", got, 1'b1);
   endtask

   task automatic wait_idle();
      bit idle = 0;
      for (int i = 0; i < 400 && !idle; i++) begin
         @(negedge clk_i);
         if (exp_q.size() == 0) idle = 1;
      end
      chk("drain", idle, 1'b1);
      @(posedge clk_i); #1;
   endtask

   task automatic pulse_clear();
      @(posedge clk_i); #1;
      ctrl.clear = 1'b1;
      @(posedge clk_i); #1;
      ctrl.clear = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [127:0] blk;
      bit got;
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] blk;
      bit got;
      rst_ni = 1'b0;
      ctrl = '0;
      blk_if.valid = 1'b0; blk_if.data = '0; blk_if.strb = '0;
      word_if.ready = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_word_valid", word_if.valid, 1'b0);
      chk("rst_blk_ready", blk_if.ready, 1'b0);
      chk("rst_flags", flags, '0);
      chk("rst_word_data", word_if.data, 32'h0);
      rst_ni = 1'b1;

      // Two back-to-back blocks with len=2.
      ctrl.enable = 1'b1; ctrl.len = 16'd2; rmode = 0;
      send_block({32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000});
      send_block({32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444});
      wait_idle();
      chk("t1_done", flags.done, 1'b1);
      chk("t1_cnt", flags.cnt, 16'd2);
      pulse_clear();

      // Stalls from a 1,0,0,1 ready pattern.
      ctrl.len = 16'd0; rmode = 1; pidx = 0;
      send_block(rnd128());
      wait_idle();
      send_block(rnd128());
      wait_idle();
      pulse_clear();

      // len=1: no further block after completion; clear reopens the input.
      ctrl.len = 16'd1; rmode = 0;
      send_block(rnd128());
      wait_idle();
      try_block(rnd128(), 10, got);
      chk("t3_refused", got, 1'b0);
      chk("t3_done", flags.done, 1'b1);
      pulse_clear();
      chk("t3_cnt_clr", flags.cnt, 16'd0);
      chk("t3_done_clr", flags.done, 1'b0);
      chk("t3_ready_back", blk_if.ready, 1'b1);

      // Enable dropped after word 1 for five cycles.
      ctrl.len = 16'd0; rmode = 3; word_if.ready = 1'b0;
      blk = rnd128();
      send_block(blk);
      word_if.ready = 1'b1;
      @(posedge clk_i); @(posedge clk_i); #1;
      ctrl.enable = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         chk("t4_no_valid", word_if.valid, 1'b0);
         chk("t4_no_ready", blk_if.ready, 1'b0);
      end
      @(posedge clk_i); #1;
      ctrl.enable = 1'b1;
      #1;
      chk("t4_word2", word_if.data, blk[95:64]);
      rmode = 0;
      wait_idle();

      // Clear with a partially sent block (index 2).
      rmode = 3; word_if.ready = 1'b0;
      send_block(rnd128());
      word_if.ready = 1'b1;
      @(posedge clk_i); @(posedge clk_i); #1;
      word_if.ready = 1'b0;
      ctrl.clear = 1'b1;
      @(posedge clk_i); #1;
      ctrl.clear = 1'b0;
      chk("t5_valid", word_if.valid, 1'b0);
      chk("t5_busy", flags.busy, 1'b0);
      rmode = 0;
      send_block(rnd128());
      wait_idle();

      // Randomized blocks, gaps and backpressure.
      for (int n = 0; n < 30; n++) begin
         rmode = ($urandom_range(0, 3) == 0) ? 0 : 2;
         repeat ($urandom_range(0, 3)) @(posedge clk_i);
         #1;
         send_block(rnd128());
      end
      rmode = 0;
      wait_idle();
      chk("rand_cnt", flags.cnt, 16'd31);

      // Asynchronous reset in the middle of a block.
      rmode = 2;
      send_block(rnd128());
      @(posedge clk_i); #3;
      rst_ni = 1'b0;
      #1;
      chk("t6_valid", word_if.valid, 1'b0);
      chk("t6_ready", blk_if.ready, 1'b0);
      chk("t6_flags", flags, '0);
      @(negedge clk_i); #2;
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("t6_cnt", flags.cnt, 16'd0);
      chk("t6_valid_after", word_if.valid, 1'b0);
      rmode = 0;
      @(posedge clk_i); #1;
      send_block(rnd128());
      wait_idle();
      chk("t6_cnt_resume", flags.cnt, 16'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
